tlb_unit: RTL and testbench
===========================

Name: tlb_unit

Overview:
- Fully associative LoongArch-style TLB: the responder to the write, read and search ports driven by the writeback stage (TLBWR/TLBFILL/TLBRD/TLBSRCH) and to the fetch and memory address translation paths.
- Holds TLBNUM entries, each with two pages (even and odd).
- Provides two combinational search ports, one combinational read port, one synchronous write port and an INVTLB invalidation engine.

Parameters:
- TLBNUM, 16, number of entries (power of two).
- IDXW, 4, index width, equal to log2(TLBNUM).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- s0_vppn / s1_vppn  input  19  search VA[31:13].
- s0_va_bit12 / s1_va_bit12  input  1  search VA[12].
- s0_asid / s1_asid  input  10  search ASID. The s1 port also supplies the INVTLB operands.
- s0_found / s1_found  output  1  hit.
- s0_index / s1_index  output  IDXW  index of the hit entry.
- s{0,1}_ppn  output  20  selected page PPN.
- s{0,1}_ps  output  6  page size.
- s{0,1}_plv  output  2  selected page PLV.
- s{0,1}_mat  output  2  selected page MAT.
- s{0,1}_d  output  1  selected page D bit.
- s{0,1}_v  output  1  selected page V bit.
- invtlb_valid  input  1  INVTLB strobe.
- invtlb_op  input  5  INVTLB opcode.
- we  input  1  write enable.
- w_index  input  IDXW  write index.
- w_e, w_ps, w_vppn, w_asid, w_g  input  1/6/19/10/1  entry fields.
- w_ppn0, w_plv0, w_mat0, w_d0, w_v0  input  20/2/2/1/1  even-page fields.
- w_ppn1, w_plv1, w_mat1, w_d1, w_v1  input  20/2/2/1/1  odd-page fields.
- r_index  input  IDXW  read index.
- r_e, r_ps, r_vppn, r_asid, r_g  output  1/6/19/10/1  read entry fields.
- r_ppn0, r_plv0, r_mat0, r_d0, r_v0  output  20/2/2/1/1  read even-page fields.
- r_ppn1, r_plv1, r_mat1, r_d1, r_v1  output  20/2/2/1/1  read odd-page fields.

Behaviour:
- Storage:
  - Per-entry registers: E, PS, VPPN, ASID, G, and page 0/1 fields {PPN, PLV, MAT, D, V}.
  - Reset clears every field of every entry to 0, so all E=0.
- Match, entry i, port k:
  - E_i && (G_i || ASID_i==sk_asid).
  - If PS_i==21: VPPN_i[18:9]==sk_vppn[18:9]. Otherwise (any PS other than 21 is treated as 4KB): VPPN_i==sk_vppn, all 19 bits.
- Page select:
  - PS==21: sk_vppn[8].
  - Otherwise: sk_va_bit12.
  - 1 selects page 1.
- Search outputs:
  - Purely combinational, zero latency.
  - Multiple hits: the lowest index wins.
  - No hit: found=0 and all other sk_* outputs are 0.
  - A search always sees pre-write contents in the cycle a write is presented.
- Read:
  - Combinational from r_index, independent of E.
  - In the cycle of a write to the same index, returns the old contents.
- Write:
  - On posedge, if we: entry w_index takes all w_* fields.
  - Visible to search/read from the next cycle.
- INVTLB:
  - Evaluated on posedge when invtlb_valid.
  - Operands are s1_asid and s1_vppn/s1_va_bit12; the match uses PS-aware VPPN compare but ignores E.
  - op 0 or 1: clear E of all entries.
  - op 2: clear E where G=1.
  - op 3: clear E where G=0.
  - op 4: clear E where G=0 && ASID==s1_asid.
  - op 5: clear E where G=0 && ASID==s1_asid && VPPN match.
  - op 6: clear E where (G=1 || ASID==s1_asid) && VPPN match.
  - op >= 7: no state change (the exception is raised upstream).
- Simultaneous we and invtlb_valid: invalidation is applied first, then the write. Entry w_index ends with E=w_e regardless of the invalidation.
- Reset asserted together with we or invtlb_valid: reset wins and all entries are cleared.
- There is no handshake; every request completes in one cycle, with no backpressure.

Optional Feature:
- Macro: TLB_WRITE_BYPASS_EN.
- Defined: in the cycle we=1, search ports and the read port see the new w_* entry at w_index (write-through forwarding). Search priority and INVTLB ordering are unchanged.
- Undefined: behaviour is exactly as stated above, with old contents visible until the next cycle.

Test Plan:
- Reset, then search s0_vppn=0x00001, asid=1 -> s0_found=0, s0_index=0, s0_ppn=0.
- Write index 3: E=1, PS=12, VPPN=0x12345, ASID=5, G=0, ppn0=0xAAAAA, ppn1=0xBBBBB, v0=v1=1.
  - Next cycle, s1 search vppn=0x12345, va_bit12=1, asid=5 -> found=1, index=3, ppn=0xBBBBB.
  - Same search with asid=6 -> found=0.
- Write index 7: PS=21, VPPN=0x40000, G=1, ppn1=0x00200. Search vppn=0x401FF (bit8=1), any asid -> found=1, index=7, ppn=0x00200, ps=21.
- Entries 2 and 9 both match the same VPPN -> index=2. Then INVTLB op=2 (entry 2 G=1, entry 9 G=0) -> next cycle the search returns index=9.
- Same cycle: we to index 4 with E=1, plus invtlb op=0 -> afterwards only entry 4 has r_e=1. An op=7 strobe changes no entry.
- Write index 5 while r_index=5 -> old data in that cycle, new data the next cycle (new data in the same cycle with TLB_WRITE_BYPASS_EN).

Source files
------------

// File: rtl/tlb_unit.sv
// tlb_unit: fully associative two-page TLB with dual search, read, write and INVTLB; optional write-through forwarding under TLB_WRITE_BYPASS_EN
module tlb_unit #(
  parameter int TLBNUM = 16,
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [18:0]     s0_vppn,
  input  logic            s0_va_bit12,
  input  logic [9:0]      s0_asid,
  output logic            s0_found,
  output logic [IDXW-1:0] s0_index,
  output logic [19:0]     s0_ppn,
  output logic [5:0]      s0_ps,
  output logic [1:0]      s0_plv,
  output logic [1:0]      s0_mat,
  output logic            s0_d,
  output logic            s0_v,
  input  logic [18:0]     s1_vppn,
  input  logic            s1_va_bit12,
  input  logic [9:0]      s1_asid,
  output logic            s1_found,
  output logic [IDXW-1:0] s1_index,
  output logic [19:0]     s1_ppn,
  output logic [5:0]      s1_ps,
  output logic [1:0]      s1_plv,
  output logic [1:0]      s1_mat,
  output logic            s1_d,
  output logic            s1_v,
  input  logic            invtlb_valid,
  input  logic [4:0]      invtlb_op,
  input  logic            we,
  input  logic [IDXW-1:0] w_index,
  input  logic            w_e,
  input  logic [5:0]      w_ps,
  input  logic [18:0]     w_vppn,
  input  logic [9:0]      w_asid,
  input  logic            w_g,
  input  logic [19:0]     w_ppn0,
  input  logic [1:0]      w_plv0,
  input  logic [1:0]      w_mat0,
  input  logic            w_d0,
  input  logic            w_v0,
  input  logic [19:0]     w_ppn1,
  input  logic [1:0]      w_plv1,
  input  logic [1:0]      w_mat1,
  input  logic            w_d1,
  input  logic            w_v1,
  input  logic [IDXW-1:0] r_index,
  output logic            r_e,
  output logic [5:0]      r_ps,
  output logic [18:0]     r_vppn,
  output logic [9:0]      r_asid,
  output logic            r_g,
  output logic [19:0]     r_ppn0,
  output logic [1:0]      r_plv0,
  output logic [1:0]      r_mat0,
  output logic            r_d0,
  output logic            r_v0,
  output logic [19:0]     r_ppn1,
  output logic [1:0]      r_plv1,
  output logic [1:0]      r_mat1,
  output logic            r_d1,
  output logic            r_v1
);
  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } page_t;
  typedef struct packed {
    logic        e;
    logic [5:0]  ps;
    logic [18:0] vppn;
    logic [9:0]  asid;
    logic        g;
    page_t       p0;
    page_t       p1;
  } entry_t;
  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] idx;
    logic [5:0]      ps;
    page_t           pg;
  } hit_t;
  entry_t tlb [TLBNUM];
  entry_t view [TLBNUM];
  entry_t w_entry;
  logic [TLBNUM-1:0] inv;
  hit_t h [2];
  logic [1:0][18:0] sv;
  logic [1:0][9:0] sa;
  logic [1:0] sb;
  // 2MB pages (PS=21) compare only VPPN[18:9]; every other size compares all 19 bits
  function automatic logic vmatch(input entry_t t, input logic [18:0] vppn);
    return t.ps == 6'd21 ? t.vppn[18:9] == vppn[18:9] : t.vppn == vppn;
  endfunction
  assign w_entry = {w_e, w_ps, w_vppn, w_asid, w_g, w_ppn0, w_plv0, w_mat0, w_d0, w_v0,
                    w_ppn1, w_plv1, w_mat1, w_d1, w_v1};
  assign sv = {s1_vppn, s0_vppn};
  assign sa = {s1_asid, s0_asid};
  assign sb = {s1_va_bit12, s0_va_bit12};
  // contents seen by search/read: stored entries, optionally overlaid by the in-flight write
  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
`ifdef TLB_WRITE_BYPASS_EN
      view[i] = (we && w_index == IDXW'(i)) ? w_entry : tlb[i];
`else
      view[i] = tlb[i];
`endif
    end
  end
  // both search ports; scanning downward lets the lowest matching index win
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      h[k] = '0;
      for (int i = TLBNUM - 1; i >= 0; i--)
        if (view[i].e && (view[i].g || view[i].asid == sa[k]) && vmatch(view[i], sv[k]))
          h[k] = '{1'b1, IDXW'(i), view[i].ps,
                   ((view[i].ps == 6'd21 ? sv[k][8] : sb[k]) ? view[i].p1 : view[i].p0)};
    end
  end
  // INVTLB selection per entry; E is deliberately ignored so stale entries are also covered
  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      inv[i] = invtlb_op <= 5'd1 ? 1'b1 :
               invtlb_op == 5'd2 ? tlb[i].g :
               invtlb_op == 5'd3 ? !tlb[i].g :
               invtlb_op == 5'd4 ? !tlb[i].g && tlb[i].asid == s1_asid :
               invtlb_op == 5'd5 ? !tlb[i].g && tlb[i].asid == s1_asid && vmatch(tlb[i], s1_vppn) :
               invtlb_op == 5'd6 ? (tlb[i].g || tlb[i].asid == s1_asid) && vmatch(tlb[i], s1_vppn) :
               1'b0;
    end
  end
  // invalidation first, then the write overrides the target entry (including its E)
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) tlb[i] <= '0;
    end else begin
      for (int i = 0; i < TLBNUM; i++) if (invtlb_valid && inv[i]) tlb[i].e <= 1'b0;
      if (we) tlb[w_index] <= w_entry;
    end
  end
  assign {s0_found, s0_index, s0_ps, s0_ppn, s0_plv, s0_mat, s0_d, s0_v} = h[0];
  assign {s1_found, s1_index, s1_ps, s1_ppn, s1_plv, s1_mat, s1_d, s1_v} = h[1];
  assign {r_e, r_ps, r_vppn, r_asid, r_g, r_ppn0, r_plv0, r_mat0, r_d0, r_v0,
          r_ppn1, r_plv1, r_mat1, r_d1, r_v1} = view[r_index];
endmodule

// File: tb/tb_tlb_unit.sv
// tb_tlb_unit: directed self-checking bench for tlb_unit
module tb_tlb_unit;
  logic clk = 0, reset;
  logic [18:0] s0_vppn, s1_vppn;
  logic s0_va_bit12, s1_va_bit12;
  logic [9:0] s0_asid, s1_asid;
  logic s0_found, s1_found, s0_d, s1_d, s0_v, s1_v;
  logic [3:0] s0_index, s1_index;
  logic [19:0] s0_ppn, s1_ppn;
  logic [5:0] s0_ps, s1_ps;
  logic [1:0] s0_plv, s1_plv, s0_mat, s1_mat;
  logic invtlb_valid, we, w_e, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [4:0] invtlb_op;
  logic [3:0] w_index, r_index;
  logic [5:0] w_ps, r_ps;
  logic [18:0] w_vppn, r_vppn;
  logic [9:0] w_asid, r_asid;
  logic [19:0] w_ppn0, w_ppn1, r_ppn0, r_ppn1;
  logic [1:0] w_plv0, w_mat0, w_plv1, w_mat1, r_plv0, r_mat0, r_plv1, r_mat1;
  logic r_e, r_g, r_d0, r_v0, r_d1, r_v1;
  int passed = 0, total = 0;

  tlb_unit dut (
    .clk(clk), .reset(reset),
    .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid), .s0_found(s0_found),
    .s0_index(s0_index), .s0_ppn(s0_ppn), .s0_ps(s0_ps), .s0_plv(s0_plv), .s0_mat(s0_mat),
    .s0_d(s0_d), .s0_v(s0_v),
    .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid), .s1_found(s1_found),
    .s1_index(s1_index), .s1_ppn(s1_ppn), .s1_ps(s1_ps), .s1_plv(s1_plv), .s1_mat(s1_mat),
    .s1_d(s1_d), .s1_v(s1_v),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
    .we(we), .w_index(w_index), .w_e(w_e), .w_ps(w_ps), .w_vppn(w_vppn), .w_asid(w_asid),
    .w_g(w_g), .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
    .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_e(r_e), .r_ps(r_ps), .r_vppn(r_vppn), .r_asid(r_asid), .r_g(r_g),
    .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
    .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic setw(input logic [3:0] idx, input logic e, input logic [5:0] ps,
                      input logic [18:0] vppn, input logic [9:0] asid, input logic g,
                      input logic [19:0] ppn0, input logic [19:0] ppn1);
    w_index = idx; w_e = e; w_ps = ps; w_vppn = vppn; w_asid = asid; w_g = g;
    w_ppn0 = ppn0; w_ppn1 = ppn1; we = 1;
  endtask

  task automatic wr(input logic [3:0] idx, input logic e, input logic [5:0] ps,
                    input logic [18:0] vppn, input logic [9:0] asid, input logic g,
                    input logic [19:0] ppn0, input logic [19:0] ppn1);
    setw(idx, e, ps, vppn, asid, g, ppn0, ppn1);
    @(posedge clk); #1 we = 0;
  endtask

  task automatic inv(input logic [4:0] op);
    invtlb_op = op; invtlb_valid = 1;
    @(posedge clk); #1 invtlb_valid = 0;
  endtask

  initial begin
    reset = 1; we = 0; invtlb_valid = 0; invtlb_op = 0; r_index = 0;
    s0_vppn = 0; s0_va_bit12 = 0; s0_asid = 0; s1_vppn = 0; s1_va_bit12 = 0; s1_asid = 0;
    w_index = 0; w_e = 0; w_ps = 0; w_vppn = 0; w_asid = 0; w_g = 0;
    w_ppn0 = 0; w_ppn1 = 0; w_plv0 = 2'd3; w_plv1 = 2'd1; w_mat0 = 2'd1; w_mat1 = 2'd2;
    w_d0 = 1; w_d1 = 1; w_v0 = 1; w_v1 = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    s0_vppn = 19'h00001; s0_asid = 10'd1; #2;
    chk("reset_found", s0_found, 0);
    chk("reset_index", s0_index, 0);
    chk("reset_ppn", s0_ppn, 0);
    chk("reset_r_e", r_e, 0);
    wr(4'd3, 1, 6'd12, 19'h12345, 10'd5, 0, 20'hAAAAA, 20'hBBBBB);
    s1_vppn = 19'h12345; s1_va_bit12 = 1; s1_asid = 10'd5; #2;
    chk("4k_found", s1_found, 1);
    chk("4k_index", s1_index, 3);
    chk("4k_ppn_odd", s1_ppn, 20'hBBBBB);
    chk("4k_mat_odd", s1_mat, 2'd2);
    s1_va_bit12 = 0; #2;
    chk("4k_ppn_even", s1_ppn, 20'hAAAAA);
    chk("4k_plv_even", s1_plv, 2'd3);
    s1_asid = 10'd6; #2;
    chk("asid_miss_found", s1_found, 0);
    chk("asid_miss_ppn", s1_ppn, 0);
    wr(4'd7, 1, 6'd21, 19'h40000, 10'd0, 1, 20'h00100, 20'h00200);
    s1_vppn = 19'h401FF; s1_asid = 10'h3FF; #2;
    chk("2m_found", s1_found, 1);
    chk("2m_index", s1_index, 7);
    chk("2m_ppn_odd", s1_ppn, 20'h00200);
    chk("2m_ps", s1_ps, 21);
    s1_vppn = 19'h400FF; #2;
    chk("2m_ppn_even", s1_ppn, 20'h00100);
    wr(4'd2, 1, 6'd12, 19'h00ABC, 10'd1, 1, 20'h22222, 20'h22223);
    wr(4'd9, 1, 6'd12, 19'h00ABC, 10'd1, 0, 20'h99999, 20'h9999A);
    s0_vppn = 19'h00ABC; s0_va_bit12 = 0; s0_asid = 10'd1; #2;
    chk("prio_index", s0_index, 2);
    chk("prio_ppn", s0_ppn, 20'h22222);
    inv(5'd2);
    #2;
    chk("op2_index", s0_index, 9);
    chk("op2_ppn", s0_ppn, 20'h99999);
    r_index = 4'd7; #1 chk("op2_clears_7", r_e, 0);
    r_index = 4'd3; #1 chk("op2_keeps_3", r_e, 1);
    s1_asid = 10'd5; inv(5'd4);
    r_index = 4'd3; #1 chk("op4_clears_3", r_e, 0);
    r_index = 4'd9; #1 chk("op4_keeps_9", r_e, 1);
    s1_asid = 10'd1; s1_vppn = 19'h00ABD; inv(5'd6);
    #1 chk("op6_vppn_miss_keeps_9", r_e, 1);
    s1_vppn = 19'h00ABC; inv(5'd6);
    #1 chk("op6_clears_9", r_e, 0);
    wr(4'd2, 1, 6'd12, 19'h00ABC, 10'd1, 1, 20'h22222, 20'h22223);
    invtlb_op = 5'd0; invtlb_valid = 1;
    wr(4'd4, 1, 6'd12, 19'h04444, 10'd2, 0, 20'h44444, 20'h44445);
    invtlb_valid = 0;
    for (int i = 0; i < 16; i++) begin
      r_index = 4'(i); #1;
      chk($sformatf("op0_we_r_e_%0d", i), r_e, (i == 4) ? 1 : 0);
    end
    inv(5'd7);
    r_index = 4'd4; #1 chk("op7_keeps_4", r_e, 1);
    s0_vppn = 19'h04444; s0_asid = 10'd2; #1;
    chk("op7_search_4", s0_index, 4);
    wr(4'd5, 1, 6'd12, 19'h05555, 10'd3, 0, 20'h55555, 20'h55556);
    @(posedge clk); #1;
    r_index = 4'd5; s0_vppn = 19'h06666; s0_asid = 10'd3;
    setw(4'd5, 1, 6'd12, 19'h06666, 10'd3, 0, 20'h66666, 20'h66667);
    #2;
`ifdef TLB_WRITE_BYPASS_EN
    chk("wr_same_cycle_read", r_ppn0, 20'h66666);
    chk("wr_same_cycle_search", s0_found, 1);
`else
    chk("wr_same_cycle_read", r_ppn0, 20'h55555);
    chk("wr_same_cycle_search", s0_found, 0);
`endif
    @(posedge clk); #1 we = 0; #1;
    chk("wr_next_read", r_ppn0, 20'h66666);
    chk("wr_next_search", s0_index, 5);
    reset = 1;
    setw(4'd0, 1, 6'd12, 19'h00000, 10'd0, 1, 20'h1, 20'h2);
    @(posedge clk); #1 reset = 0; we = 0;
    r_index = 4'd0; #1 chk("reset_beats_we", r_e, 0);
    r_index = 4'd5; #1 chk("reset_clears_5", r_e, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
